// File: rtl/video_timing_pkg.sv
// Shared VGA timing defaults and the receive-side lock FSM encoding.
package video_timing_pkg;

    localparam int H_ACTIVE_DEF   = 800;
    localparam int H_FRONT_DEF    = 56;
    localparam int H_SYNC_DEF     = 120;
    localparam int H_BACK_DEF     = 64;
    localparam int H_TOTAL        = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF   = 600;
    localparam int V_FRONT_DEF    = 37;
    localparam int V_SYNC_DEF     = 6;
    localparam int V_BACK_DEF     = 23;
    localparam int V_TOTAL        = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int SYNC_POL_DEF   = 0;
    localparam int H_TOL_DEF      = 2;
    localparam int LOCK_LINES_DEF = 8;

    // state      | meaning
    // SEARCH     | no line reference yet, waiting for an hsync start
    // TRACK      | counting consecutive in-tolerance lines
    // FRAME      | lines stable, waiting for the first (partial) vsync
    // FRAME_WAIT | measuring one full frame
    // LOCKED     | timing locked, active window driven
    typedef enum logic [2:0] {
        SEARCH     = 3'd0,
        TRACK      = 3'd1,
        FRAME      = 3'd2,
        FRAME_WAIT = 3'd3,
        LOCKED     = 3'd4
    } sync_state_t;

    // Signed 12-bit difference so window and tolerance checks never underflow.
    function automatic logic signed [11:0] offset_s12(input logic [11:0] val, input int off);
        logic [11:0] off_u;
        off_u = 12'(off);
        return $signed(val) - $signed(off_u);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register; pulses start on the transition into
// the active sync level. Everything advances only on ce.
module sync_edge_detect #(
    parameter int SYNC_POL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic sync_in,
    output logic start
);
    localparam logic ACT = (SYNC_POL != 0);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= ~ACT;
            sync <= ~ACT;
            prev <= ~ACT;
        end else if (ce) begin
            meta <= sync_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign start = ce && (sync == ACT) && (prev != ACT);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming h/v sync, measures line and frame
// length, and drives de/pix_x/pix_y once the timing has locked.
module vga_sync_decoder
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_POL   = SYNC_POL_DEF,
    parameter int H_TOL      = H_TOL_DEF,
    parameter int LOCK_LINES = LOCK_LINES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        sync_err
);
    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic signed [11:0] TOL   = 12'(H_TOL);
    localparam logic signed [11:0] X_LIM = 12'(H_ACTIVE);
    localparam logic signed [11:0] Y_LIM = 12'(V_ACTIVE);
    localparam logic [10:0] H_MAX = 11'h7FF;
    localparam logic [9:0]  V_MAX = 10'h3FF;
    localparam logic [7:0]  GOOD_NEEDED = 8'(LOCK_LINES);

    logic               hs_start;
    logic               vs_start;
    logic [10:0]        h_cnt;
    logic [9:0]         v_cnt;
    logic [11:0]        len_ext;
    logic [10:0]        len_new;
    logic signed [11:0] h_diff;
    logic signed [11:0] xa;
    logic signed [11:0] ya;
    logic               line_good;
    logic               bad_line;
    logic               frame_good;
    logic               x_ok;
    logic               y_ok;
    logic               win_nx;
    logic               lost;
    sync_state_t        state;
    sync_state_t        state_nx;
    logic [7:0]         good_cnt;
    logic [7:0]         good_cnt_nx;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk     (clk),
        .rst     (rst),
        .ce      (pix_ce),
        .sync_in (h_sync_in),
        .start   (hs_start)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk     (clk),
        .rst     (rst),
        .ce      (pix_ce),
        .sync_in (v_sync_in),
        .start   (vs_start)
    );

    // A saturated counter reports the largest representable length rather than wrapping to 0.
    assign len_ext    = {1'b0, h_cnt} + 12'd1;
    assign len_new    = len_ext[11] ? H_MAX : len_ext[10:0];
    assign h_diff     = offset_s12(len_ext, H_TOT);
    assign line_good  = (h_diff >= -TOL) && (h_diff <= TOL);
    assign bad_line   = hs_start && !line_good;
    assign frame_good = (v_cnt == 10'(V_TOT));

    assign xa     = offset_s12({1'b0, h_cnt}, H_SYNC + H_BACK);
    assign ya     = offset_s12({2'b0, v_cnt}, V_SYNC + V_BACK);
    assign x_ok   = (xa >= 12'sd0) && (xa < X_LIM);
    assign y_ok   = (ya >= 12'sd0) && (ya < Y_LIM);
    assign win_nx = (state_nx == LOCKED) && x_ok && y_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else if (pix_ce) begin
            if (hs_start) begin
                line_len <= len_new;
                h_cnt    <= '0;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (vs_start) begin
                frame_lines <= v_cnt;
                v_cnt       <= '0;
            end else if (hs_start && v_cnt != V_MAX) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else if (pix_ce) begin
            state    <= state_nx;
            good_cnt <= good_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        good_cnt_nx = good_cnt;
        lost        = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_start) begin
                    state_nx    = TRACK;
                    good_cnt_nx = '0;
                end
            end
            TRACK: begin
                if (good_cnt == GOOD_NEEDED) begin
                    state_nx = FRAME;
                end else if (hs_start) begin
                    good_cnt_nx = line_good ? good_cnt + 8'd1 : 8'd0;
                end
            end
            FRAME: begin
                if (bad_line) begin
                    state_nx    = TRACK;
                    good_cnt_nx = '0;
                end else if (vs_start) begin
                    state_nx = FRAME_WAIT;
                end
            end
            FRAME_WAIT: begin
                if (bad_line) begin
                    state_nx    = TRACK;
                    good_cnt_nx = '0;
                end else if (vs_start) begin
                    state_nx = frame_good ? LOCKED : SEARCH;
                end
            end
            LOCKED: begin
                if (bad_line || (vs_start && !frame_good) || h_cnt == H_MAX) begin
                    state_nx = SEARCH;
                    lost     = 1'b1;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de     <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
            locked <= 1'b0;
        end else if (pix_ce) begin
            de     <= win_nx;
            pix_x  <= win_nx ? xa[9:0] : 10'd0;
            pix_y  <= win_nx ? ya[9:0] : 10'd0;
            locked <= (state_nx == LOCKED);
        end
    end

    // Pulses are re-evaluated every clock so they never stretch across a held pix_ce.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_start <= pix_ce && win_nx && (xa == 12'sd0) && (ya == 12'sd0);
            sync_err    <= pix_ce && lost;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 32x17 raster so every
// scenario fits in a short run; pix_ce is asserted every second clock.
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 4, HSW = 6, HB = 6, HT = 32;
    localparam int VA = 10, VF = 2, VSW = 2, VB = 3, VT = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        de;
    logic        frame_start;
    logic        locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic        sync_err;

    int n_chk = 0;
    int n_err = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    int fs_cnt, de_acc, frame_de, px_cnt, lock_at, max_x, max_y;
    int vs_off = 16;
    int e0;
    logic [9:0] fs_x, fs_y;
    logic       fs_de;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .SYNC_POL(0), .H_TOL(2), .LOCK_LINES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .de          (de),
        .frame_start (frame_start),
        .locked      (locked),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // One pixel: a ce clock followed by an idle clock; outputs sampled 1 time unit after each edge.
    task automatic step_px(input logic hs, input logic vs);
        h_sync_in = hs;
        v_sync_in = vs;
        pix_ce    = 1'b1;
        @(posedge clk); #1;
        px_cnt++;
        if (sync_err) err_cnt++;
        if (locked && lock_at < 0) lock_at = px_cnt;
        if (frame_start) begin
            fs_cnt++;
            if (fs_cnt == 1) begin
                fs_x  = pix_x;
                fs_y  = pix_y;
                fs_de = de;
            end else begin
                frame_de = de_acc;
            end
            de_acc = 0;
        end
        if (de) begin
            de_acc++;
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
            if (int'(pix_y) > max_y) max_y = int'(pix_y);
        end
        pix_ce = 1'b0;
        @(posedge clk); #1;
        if (frame_start || sync_err) wide_cnt++;
    endtask

    // Active-low syncs; vsync spans VSW lines starting vs_off pixels into line 0.
    task automatic gen_px(input int l, input int hp);
        int p;
        p = l * HT + hp;
        step_px(hp >= HSW, !(p >= vs_off && p < vs_off + VSW * HT));
    endtask

    task automatic gen_lines(input int from, input int to, input int len);
        for (int l = from; l <= to; l++)
            for (int hp = 0; hp < len; hp++)
                gen_px(l, hp);
    endtask

    task automatic frames(input int n);
        repeat (n) gen_lines(0, VT - 1, HT);
    endtask

    initial begin
        rst = 1'b1; pix_ce = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", de, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_locked", locked, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_frame_lines", frame_lines, 0);
        chk("rst_sync_err", sync_err, 0);
        rst = 1'b0; pix_ce = 1'b0;
        @(posedge clk); #1;

        // 1: nominal acquisition
        fs_cnt = 0; de_acc = 0; frame_de = 0; px_cnt = 0; lock_at = -1; max_x = 0; max_y = 0;
        frames(5);
        chk("t1_locked", locked, 1);
        chk("t1_lock_time", (lock_at >= 0) && (lock_at <= 8 * HT + 2 * VT * HT), 1);
        chk("t1_line_len", line_len, HT);
        chk("t1_frame_lines", frame_lines, VT);
        chk("t1_frame_starts", fs_cnt, 3);
        chk("t1_de_per_frame", frame_de, HA * VA);
        chk("t1_fs_x", fs_x, 0);
        chk("t1_fs_y", fs_y, 0);
        chk("t1_fs_de", fs_de, 1);
        chk("t1_max_x", max_x, HA - 1);
        chk("t1_max_y", max_y, VA - 1);
        chk("t1_no_err", err_cnt, 0);

        // 2: one line one pixel long stays within tolerance
        e0 = err_cnt;
        gen_lines(0, 7, HT);
        gen_lines(8, 8, HT + 1);
        gen_lines(9, 9, HT);
        chk("t2_line_len", line_len, HT + 1);
        chk("t2_locked_mid", locked, 1);
        gen_lines(10, VT - 1, HT);
        chk("t2_locked", locked, 1);
        chk("t2_no_err", err_cnt - e0, 0);

        // 3: line five pixels long breaks lock, then relock
        e0 = err_cnt;
        gen_lines(0, 7, HT);
        gen_lines(8, 8, HT + 5);
        gen_lines(9, 9, HT);
        chk("t3_line_len", line_len, HT + 5);
        chk("t3_err_pulses", err_cnt - e0, 1);
        chk("t3_locked", locked, 0);
        chk("t3_de", de, 0);
        gen_lines(10, VT - 1, HT);
        frames(3);
        chk("t3_relocked", locked, 1);

        // 4: hsync stuck inactive, counter saturation drops lock
        e0 = err_cnt;
        gen_lines(0, 9, HT);
        repeat (2100) step_px(1'b1, 1'b1);
        chk("t4_err_pulses", err_cnt - e0, 1);
        chk("t4_locked", locked, 0);
        chk("t4_de", de, 0);
        frames(3);
        chk("t4_relocked", locked, 1);

        // 5: reset mid active line
        gen_lines(0, 7, HT);
        for (int hp = 0; hp <= 20; hp++) gen_px(8, hp);
        chk("t5_pre_de", de, 1);
        chk("t5_pre_pix_x", pix_x, 5);
        chk("t5_pre_pix_y", pix_y, 3);
        rst = 1'b1; pix_ce = 1'b1;
        @(posedge clk); #1;
        chk("t5_de", de, 0);
        chk("t5_pix_x", pix_x, 0);
        chk("t5_pix_y", pix_y, 0);
        chk("t5_locked", locked, 0);
        chk("t5_line_len", line_len, 0);
        chk("t5_frame_lines", frame_lines, 0);
        rst = 1'b0; pix_ce = 1'b0;
        @(posedge clk); #1;
        frames(3);
        chk("t5_relocked", locked, 1);
        chk("t5_line_len_after", line_len, HT);
        chk("t5_frame_lines_after", frame_lines, VT);

        // 6a: pix_ce held low mid line while sync inputs wiggle
        gen_lines(0, 7, HT);
        for (int hp = 0; hp <= 20; hp++) gen_px(8, hp);
        for (int c = 0; c < 50; c++) begin
            h_sync_in = (c < 10 || c >= 30);
            v_sync_in = (c % 7 != 0);
            @(posedge clk); #1;
            if (frame_start || sync_err) wide_cnt++;
        end
        chk("t6_hold_pix_x", pix_x, 5);
        chk("t6_hold_pix_y", pix_y, 3);
        chk("t6_hold_de", de, 1);
        chk("t6_hold_locked", locked, 1);
        chk("t6_hold_line_len", line_len, HT);
        chk("t6_hold_frame_lines", frame_lines, VT);
        gen_px(8, 21);
        chk("t6_resume_pix_x", pix_x, 6);
        for (int hp = 22; hp < HT; hp++) gen_px(8, hp);
        gen_lines(9, VT - 1, HT);
        chk("t6_line_len", line_len, HT);
        chk("t6_locked", locked, 1);

        // 6b: hsync and vsync start on the same sample; vsync wins the v_cnt update
        e0 = err_cnt;
        vs_off = 0;
        gen_lines(0, 0, HT);
        chk("t6_coinc_frame_lines", frame_lines, VT - 1);
        chk("t6_coinc_err", err_cnt - e0, 1);
        chk("t6_coinc_locked", locked, 0);
        gen_lines(1, VT - 1, HT);
        vs_off = 16;
        gen_lines(0, 0, HT);
        chk("t6_next_frame_lines", frame_lines, VT);

        chk("pulse_width", wide_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
